// File: rtl/alu_result_fifo.sv
// In-order result FIFO behind the ALU: stores op code, result, carry, remainder, product and flags.
// Optional push/carry statistics counters are enabled with ALU_RES_STATS_EN.
module alu_result_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_control,
   input  logic [WIDTH-1:0]           in_result,
   input  logic                       in_cout,
   input  logic [WIDTH-1:0]           in_remainder,
   input  logic [2*WIDTH-1:0]         in_product,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 out_control,
   output logic [WIDTH-1:0]           out_result,
   output logic                       out_cout,
   output logic [WIDTH-1:0]           out_remainder,
   output logic [2*WIDTH-1:0]         out_product,
   output logic                       out_zero,
   output logic                       out_neg,
   output logic                       out_err,
`ifdef ALU_RES_STATS_EN
   output logic [15:0]                stat_accepted,
   output logic [15:0]                stat_carry,
`endif
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
   localparam logic [3:0] OpMul = 4'b1010;
   localparam logic [3:0] OpIllegalMin = 4'b1100;

   typedef struct packed {
      logic [3:0]         control;
      logic [WIDTH-1:0]   result;
      logic               cout;
      logic [WIDTH-1:0]   remainder;
      logic [2*WIDTH-1:0] product;
      logic               zero;
      logic               neg;
      logic               err;
   } entry_t;

   entry_t            mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;

   logic   push, pop, wr_en;
   entry_t new_entry;
   entry_t head;

   assign in_ready  = (count_q < CntFull);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   // A flush discards any push in the same cycle, so storage is left untouched.
   assign wr_en     = push & ~flush;
   assign count     = count_q;

   always_comb begin
      new_entry           = '0;
      new_entry.control   = in_control;
      new_entry.result    = in_result;
      new_entry.cout      = in_cout;
      new_entry.remainder = in_remainder;
      new_entry.product   = in_product;
      new_entry.err       = (in_control >= OpIllegalMin);
      if (in_control == OpMul) begin
         new_entry.zero = (in_product == '0);
         new_entry.neg  = in_product[2*WIDTH-1];
      end else begin
         new_entry.zero = (in_result == '0);
         new_entry.neg  = in_result[WIDTH-1];
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_ptr_q] <= new_entry;
      end
   end

   // Head fields read as zero whenever the FIFO is empty.
   always_comb begin
      head = '0;
      if (out_valid) begin
         head = mem_q[rd_ptr_q];
      end
   end

   assign out_control   = head.control;
   assign out_result    = head.result;
   assign out_cout      = head.cout;
   assign out_remainder = head.remainder;
   assign out_product   = head.product;
   assign out_zero      = head.zero;
   assign out_neg       = head.neg;
   assign out_err       = head.err;

`ifdef ALU_RES_STATS_EN
   logic [15:0] stat_accepted_q, stat_accepted_d;
   logic [15:0] stat_carry_q, stat_carry_d;

   always_comb begin
      stat_accepted_d = stat_accepted_q;
      stat_carry_d    = stat_carry_q;
      if (wr_en) begin
         stat_accepted_d = stat_accepted_q + 16'd1;
         if (in_cout) begin
            stat_carry_d = stat_carry_q + 16'd1;
         end
      end
   end

   // Statistics survive a flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_accepted_q <= '0;
         stat_carry_q    <= '0;
      end else begin
         stat_accepted_q <= stat_accepted_d;
         stat_carry_q    <= stat_carry_d;
      end
   end

   assign stat_accepted = stat_accepted_q;
   assign stat_carry    = stat_carry_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized bench for alu_result_fifo with a queue-based reference model and directed checks.
module tb_alu_result_fifo;

   localparam int W = 4;
   localparam int D = 4;
   localparam int CW = $clog2(D) + 1;

   logic            clk = 1'b0;
   logic            rst, in_valid, in_cout, flush, out_ready;
   logic [3:0]      in_control;
   logic [W-1:0]    in_result, in_remainder;
   logic [2*W-1:0]  in_product;
   logic            in_ready, out_valid, out_cout, out_zero, out_neg, out_err;
   logic [3:0]      out_control;
   logic [W-1:0]    out_result, out_remainder;
   logic [2*W-1:0]  out_product;
   logic [CW-1:0]   count;
`ifdef ALU_RES_STATS_EN
   logic [15:0]     stat_accepted, stat_carry;
   logic [15:0]     m_acc, m_car, acc_before;
`endif

   always #5 clk = ~clk;

   alu_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_control   (in_control),
      .in_result    (in_result),
      .in_cout      (in_cout),
      .in_remainder (in_remainder),
      .in_product   (in_product),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_control  (out_control),
      .out_result   (out_result),
      .out_cout     (out_cout),
      .out_remainder(out_remainder),
      .out_product  (out_product),
      .out_zero     (out_zero),
      .out_neg      (out_neg),
      .out_err      (out_err),
`ifdef ALU_RES_STATS_EN
      .stat_accepted(stat_accepted),
      .stat_carry   (stat_carry),
`endif
      .count        (count)
   );

   typedef struct {
      logic [3:0]     ctrl;
      logic [W-1:0]   res;
      logic           cout;
      logic [W-1:0]   rem;
      logic [2*W-1:0] prod;
      logic           zero;
      logic           neg;
      logic           err;
   } ent_t;

   ent_t m_q[$];
   int   total = 0;
   int   bad = 0;
   bit   started = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t mk();
      ent_t e;
      e.ctrl = in_control;
      e.res  = in_result;
      e.cout = in_cout;
      e.rem  = in_remainder;
      e.prod = in_product;
      e.err  = (in_control >= 4'd12);
      if (in_control == 4'd10) begin
         e.zero = (in_product == 0);
         e.neg  = in_product[2*W-1];
      end else begin
         e.zero = (in_result == 0);
         e.neg  = in_result[W-1];
      end
      return e;
   endfunction

   // One clock edge; the model absorbs the inputs that were stable at that edge.
   task automatic tick();
      bit   do_push, do_pop;
      ent_t e, tmp;
      e = mk();
      @(posedge clk);
      if (rst) begin
         m_q.delete();
`ifdef ALU_RES_STATS_EN
         m_acc = 0;
         m_car = 0;
`endif
      end else if (flush) begin
         m_q.delete();
      end else begin
         do_push = in_valid && (m_q.size() < D);
         do_pop  = out_ready && (m_q.size() > 0);
`ifdef ALU_RES_STATS_EN
         if (do_push) begin
            m_acc = m_acc + 16'd1;
            if (e.cout) m_car = m_car + 16'd1;
         end
`endif
         if (do_pop) tmp = m_q.pop_front();
         if (do_push) m_q.push_back(e);
      end
      started = 1;
      #1;
   endtask

   always @(negedge clk) begin
      ent_t h;
      if (started) begin
         if (m_q.size() > 0) begin
            h = m_q[0];
         end else begin
            h = '{default: '0};
         end
         check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
         check("in_ready", 64'(in_ready), 64'(m_q.size() < D));
         check("count", 64'(count), 64'(m_q.size()));
         check("out_control", 64'(out_control), 64'(h.ctrl));
         check("out_result", 64'(out_result), 64'(h.res));
         check("out_cout", 64'(out_cout), 64'(h.cout));
         check("out_remainder", 64'(out_remainder), 64'(h.rem));
         check("out_product", 64'(out_product), 64'(h.prod));
         check("out_zero", 64'(out_zero), 64'(h.zero));
         check("out_neg", 64'(out_neg), 64'(h.neg));
         check("out_err", 64'(out_err), 64'(h.err));
`ifdef ALU_RES_STATS_EN
         check("stat_accepted", 64'(stat_accepted), 64'(m_acc));
         check("stat_carry", 64'(stat_carry), 64'(m_car));
`endif
      end
   end

   task automatic push_one(input logic [3:0] c, input logic [W-1:0] r, input logic [2*W-1:0] p);
      in_valid   = 1'b1;
      in_control = c;
      in_result  = r;
      in_product = p;
      tick();
      in_valid   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_control = '0; in_result = '0; in_cout = 1'b0; in_remainder = '0; in_product = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_count", 64'(count), 64'd0);
      check("rst_result", 64'(out_result), 64'd0);

      // Single add
      in_cout = 1'b1;
      push_one(4'b1000, 4'b0100, 8'h00);
      in_cout = 1'b0;
      check("add_valid", 64'(out_valid), 64'd1);
      check("add_result", 64'(out_result), 64'h4);
      check("add_cout", 64'(out_cout), 64'd1);
      check("add_zero", 64'(out_zero), 64'd0);
      check("add_neg", 64'(out_neg), 64'd0);
      check("add_count", 64'(count), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("add_popped", 64'(out_valid), 64'd0);

      // Fill, overflow attempt, ordered drain, then wrap
      for (int i = 1; i <= 4; i++) push_one(4'b0000, W'(i), 8'h00);
      check("full_ready", 64'(in_ready), 64'd0);
      check("full_count", 64'(count), 64'd4);
      push_one(4'b0000, 4'd5, 8'h00);
      check("overflow_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("order", 64'(out_result), 64'(i));
         tick();
      end
      out_ready = 1'b0;
      check("drained", 64'(count), 64'd0);
      push_one(4'b0000, 4'd6, 8'h00);
      push_one(4'b0000, 4'd7, 8'h00);
      out_ready = 1'b1;
      check("wrap6", 64'(out_result), 64'd6);
      tick();
      check("wrap7", 64'(out_result), 64'd7);
      tick();
      out_ready = 1'b0;

      // Multiply flags come from the product
      push_one(4'b1010, 4'b1111, 8'h00);
      check("mul0_zero", 64'(out_zero), 64'd1);
      check("mul0_neg", 64'(out_neg), 64'd0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      push_one(4'b1010, 4'b0000, 8'h80);
      check("mul80_neg", 64'(out_neg), 64'd1);
      check("mul80_zero", 64'(out_zero), 64'd0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Concurrent push/pop at count=2
      push_one(4'b0001, 4'd3, 8'h00);
      push_one(4'b0001, 4'd5, 8'h00);
      out_ready = 1'b1;
      push_one(4'b0001, 4'd9, 8'h00);
      check("conc_count", 64'(count), 64'd2);
      check("conc_head", 64'(out_result), 64'd5);
      tick(); tick();
      out_ready = 1'b0;
      check("conc_empty", 64'(count), 64'd0);

      // Illegal op
      push_one(4'b1101, 4'd2, 8'h11);
      check("illegal_err", 64'(out_err), 64'd1);
      check("illegal_res", 64'(out_result), 64'd2);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Flush with concurrent push and pop
      for (int i = 0; i < 3; i++) push_one(4'b0000, W'(i + 1), 8'h00);
`ifdef ALU_RES_STATS_EN
      acc_before = stat_accepted;
`endif
      flush = 1'b1; out_ready = 1'b1;
      push_one(4'b0000, 4'hA, 8'h00);
      flush = 1'b0;
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_ready", 64'(in_ready), 64'd1);
`ifdef ALU_RES_STATS_EN
      check("flush_stat", 64'(stat_accepted), 64'(acc_before));
`endif
      tick();
      check("flush_gone", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         out_ready    = ($urandom_range(0, 2) != 0);
         in_control   = 4'($urandom);
         in_result    = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
         in_product   = ($urandom_range(0, 5) == 0) ? '0 : (2*W)'($urandom);
         in_remainder = W'($urandom);
         in_cout      = 1'($urandom);
         flush        = ($urandom_range(0, 40) == 0);
         rst          = ($urandom_range(0, 300) == 0);
         tick();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the parameterized ALU. Captures one ALU outcome per accepted request: op code, result, cout, remainder and product.
- Derives status flags and buffers the outcomes in a DEPTH-entry in-order FIFO, with valid/ready handshakes on both sides.
- Decouples the combinational ALU from consumers such as the writeback and flag register.

Parameters:
- WIDTH, 4, operand/result width; matches the ALU WIDTH; legal 4..32.
- DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  ALU outcome present.
- in_ready  output  1  FIFO can accept (count < DEPTH).
- in_control  input  4  op code applied to the ALU this cycle.
- in_result  input  WIDTH  ALU result.
- in_cout  input  1  ALU carry/borrow out.
- in_remainder  input  WIDTH  ALU remainder.
- in_product  input  2*WIDTH  ALU product.
- flush  input  1  synchronous FIFO clear.
- out_valid  output  1  head entry valid (count != 0).
- out_ready  input  1  consumer takes head.
- out_control  output  4  head op code.
- out_result  output  WIDTH  head result.
- out_cout  output  1  head carry.
- out_remainder  output  WIDTH  head remainder.
- out_product  output  2*WIDTH  head product.
- out_zero  output  1  head zero flag.
- out_neg  output  1  head sign flag.
- out_err  output  1  head illegal-op flag.
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst=1 at edge):
  - count, rd_ptr and wr_ptr are cleared to 0.
  - out_valid=0 and in_ready=1.
  - All out_* data fields read 0 while empty; entry storage is zeroed on reset.
- Push and pop:
  - Push happens when in_valid & in_ready.
  - Pop happens when out_valid & out_ready.
  - in_ready depends only on count; there is no combinational path from out_ready. When full, no push is possible even if a pop occurs in the same cycle.
- Latency:
  - An entry pushed at edge N is visible on out_* and out_valid after edge N, i.e. one-cycle latency through an empty FIFO.
  - out_* are driven combinationally from storage[rd_ptr] and are gated to 0 when empty.
- Flags, computed at push time and stored with the entry:
  - sel = in_product when in_control==4'b1010, else zero-extended in_result.
  - zero = (sel == 0).
  - neg = MSB of in_product for op 1010, else in_result[WIDTH-1].
  - err = (in_control >= 4'b1100); for err entries, result, cout, remainder and product are stored as received.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- flush: highest priority after rst. It clears count and pointers, and any same-cycle push or pop is discarded. Storage contents are not cleared.
- Overflow and underflow are not possible: pushes with in_ready=0 and pops with out_valid=0 are ignored with no state change.
- rst or flush asserted mid-stream drops all held entries; out_valid is low the following cycle.

Optional Feature:
- Macro: ALU_RES_STATS_EN.
- When defined, two extra output ports are added:
  - stat_accepted (16 bits): increments on every push.
  - stat_carry (16 bits): increments on pushes with in_cout=1.
- Both counters wrap at 16'hFFFF->0 and clear on rst only; flush does not clear them.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset check:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: out_valid=0, in_ready=1, count=0, out_result=0.
- Single add (WIDTH=4):
  - Stimulus: push control=1000, result=0100, cout=1 with out_ready=0.
  - Required next cycle: out_valid=1, out_result=0100, out_cout=1, out_zero=0, out_neg=0, count=1. Pop, then out_valid=0.
- Fill and order:
  - Stimulus: push results 1,2,3,4 with out_ready=0, then attempt a 5th push of result 5.
  - Required: in_ready=0 and count=4; the 5th is ignored. Pops return 1,2,3,4 in order, and pointer wrap is exercised by pushing 6,7 afterward.
- Multiply flag source:
  - Stimulus: push control=1010, product=8'h00, result=1111.
  - Required: out_zero=1 and out_neg=0 (flags taken from product).
  - Stimulus: push control=1010, product=8'h80.
  - Required: out_neg=1, out_zero=0.
- Concurrent and illegal:
  - Stimulus: at count=2, push and pop in the same cycle.
  - Required: count stays 2, head advances.
  - Stimulus: push control=1101.
  - Required: out_err=1 when it reaches the head.
- Flush priority:
  - Stimulus: count=3; assert flush together with in_valid=1 and out_ready=1.
  - Required next cycle: count=0, out_valid=0, in_ready=1; the pushed entry is never popped.
  - With ALU_RES_STATS_EN defined: stat_accepted is unchanged by the flush-cycle push.
